// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit slice per clock, LSB nibble first, carry held in a register.
// Latency N=WIDTH/4 RUN cycles then a one-cycle done; start while busy is ignored.
// Optional subtract mode (port sub) is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               sub_q, sub_d;
    logic               sub_in;

    logic [IDX_W+1:0]   lo;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [4:0]         sum5;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // The single 4-bit slice adder; operands are muxed by the slice index.
    assign lo    = {idx_q, 2'b00};
    assign a_nib = a_q[lo +: 4];
    assign b_nib = sub_q ? ~b_q[lo +: 4] : b_q[lo +: 4];
    assign sum5  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        sub_d   = sub_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in;
                    // Subtraction is a + ~b + 1, so the initial carry is forced.
                    carry_d = sub_in ? 1'b1 : cin;
                    s_d     = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_d[lo +: 4] = sum5[3:0];
                carry_d      = sum5[4];
                if (idx_q == LAST_IDX) begin
                    cout_d  = sum5[4];
                    ovf_d   = (a_q[WIDTH-1] == b_nib[3]) && (sum5[3] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            sub_q   <= sub_d;
        end
    end

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign s     = s_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Holds the inter-slice carry in a register and assembles the result over WIDTH/4 cycles.
- Handshake is start/ready/busy/done.
- Sits between a requesting datapath and the shared 4-bit adder. It is the area-lean alternative to a WIDTH-bit combinational adder.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and >= 8. N = WIDTH/4 slices.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- a  input  WIDTH  operand A, sampled on the accepting edge
- b  input  WIDTH  operand B, sampled on the accepting edge
- cin  input  1  initial carry, sampled on the accepting edge
- ready  output  1  high in IDLE and DONE
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, result valid
- s  output  WIDTH  sum, registered
- cout  output  1  carry out of bit WIDTH-1, registered
- ovf  output  1  signed overflow of the full-width add, registered

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, slice index=0, carry reg=0, operand regs=0, s=0, cout=0, ovf=0, done=0, busy=0, ready=1. Reset mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE or DONE with start=1: latch a, b, cin; clear s; index=0; go to RUN. DONE with start=0: go to IDLE.
- RUN, each edge: slice adder computes a_reg[4i+3:4i] + b_reg[4i+3:4i] + carry, with i = index.
  - Write the 4-bit sum into s[4i+3:4i] and load the slice carry-out into the carry reg.
  - If i < N-1: increment index and stay in RUN.
  - If i = N-1: load cout, compute ovf, go to DONE, set done=1.
- Latency: start accepted at edge E, so done is high in the cycle following edge E+N. busy is high for exactly N cycles.
- Back-to-back: start=1 while done=1 is accepted, so throughput is one op per N+1 cycles.
- start while busy=1 is ignored. Operand inputs are don't-care except on the accepting edge.
- s and cout are undefined-but-stable during RUN; partial nibbles are visible. s, cout and ovf hold their values from DONE until the next accepted start.
- ovf = (a_reg[W-1] == b_eff[W-1]) && (s[W-1] != a_reg[W-1]), where b_eff is the effective B operand.
- Arithmetic is modulo 2^WIDTH; the carry beyond cout is discarded.
- The 4-bit slice adder is the only arithmetic resource. No WIDTH-bit '+' may be inferred.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on the accepting edge.
  - With latched sub=1: each B slice is bitwise inverted before the adder, and the initial carry reg is forced to 1 (cin ignored). Result is a-b mod 2^WIDTH; cout=1 means no borrow.
  - ovf uses the inverted B MSB as b_eff.
  - With latched sub=0: identical to the add-only block.
- Undefined: port sub absent; add-only behaviour; b_eff = b_reg.

Test Plan (WIDTH=16, N=4):
- Reset, then a=0xFFFF, b=0x0001, cin=0, start pulse -> busy for 4 cycles, done one cycle later; s=0x0000, cout=1, ovf=0. After done: ready=1, done=0.
- a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x4321, cin=1 -> s=0x5556, cout=0, ovf=0.
- start held high continuously with a=0x0001, b=0x0001, cin=0 -> done pulses every 5 cycles, each with s=0x0002. start pulses during RUN with different operands do not change the result.
- rst asserted at the 2nd RUN cycle -> next cycle: IDLE, ready=1, s=0, cout=0, no done. A new add 0x00FF+0x0001 then gives s=0x0100.
- NIBBLE_SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=0x0005, b=0x0007 -> s=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
  - With sub=0, the add tests above give the same results.
